// File: rtl/adder_pkg.sv
// Shared arithmetic definitions: FSM state encoding and sizing helpers
// for the multiword adder.
package adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int slice_count(input int w, input int n);
    return w / n;
  endfunction

  // One extra bit so idx can represent K itself without wrapping.
  function automatic int idx_width(input int k);
    return $clog2(k) + 1;
  endfunction

endpackage

// File: rtl/carry_lookahead_adder.sv
// N-bit carry-lookahead adder: every carry is expanded directly from the
// generate/propagate terms and cin instead of rippling through lower bits.
module carry_lookahead_adder #(
  parameter int N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout
);

  logic [N-1:0] g;
  logic [N-1:0] p;
  logic [N:0]   c;

  assign g    = a & b;
  assign p    = a ^ b;
  assign c[0] = cin;

  for (genvar gi = 0; gi < N; gi++) begin : g_carry
    logic cy;

    // c[gi+1] = g[gi] | p[gi]g[gi-1] | ... | p[gi..0]cin
    always_comb begin
      logic term;
      logic prop;
      term = 1'b0;
      prop = 1'b1;
      for (int j = gi; j >= 0; j--) begin
        term = term | (prop & g[j]);
        prop = prop & p[j];
      end
      cy = term | (prop & cin);
    end

    assign c[gi+1] = cy;
  end

  assign sum  = p ^ c[N-1:0];
  assign cout = c[N];

endmodule

// File: rtl/multiword_adder.sv
// Sequential W-bit adder that processes one N-bit slice per cycle through a
// single carry-lookahead slice, with a valid/ready handshake on both sides.
module multiword_adder
  import adder_pkg::*;
#(
  parameter int W = 32,
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         busy
);

  localparam int K  = slice_count(W, N);
  localparam int IW = idx_width(K);

  if (N < 1 || W < N || (W % N) != 0) begin : g_param_check
    $error("multiword_adder: W (%0d) must be a positive multiple of N (%0d)", W, N);
  end

  state_t        state_reg;
  state_t        state_next;
  logic [IW-1:0] idx_reg;
  logic [W-1:0]  a_reg;
  logic [W-1:0]  b_reg;
  logic [W-1:0]  sum_reg;
  logic          carry_reg;
  logic          cout_reg;

  logic [N-1:0]  slice_a;
  logic [N-1:0]  slice_b;
  logic [N-1:0]  slice_sum;
  logic          slice_cout;
  logic          last_slice;
  logic          accept;

  assign last_slice = (idx_reg == IW'(K - 1));
  assign accept     = in_valid && in_ready;

  always_comb begin
    slice_a = '0;
    slice_b = '0;
    for (int k = 0; k < K; k++) begin
      if (idx_reg == IW'(k)) begin
        slice_a = a_reg[k*N +: N];
        slice_b = b_reg[k*N +: N];
      end
    end
  end

  carry_lookahead_adder #(
    .N(N)
  ) u_slice_adder (
    .a   (slice_a),
    .b   (slice_b),
    .cin (carry_reg),
    .sum (slice_sum),
    .cout(slice_cout)
  );

  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b0;
    case (state_reg)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last_slice) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        // A handoff cycle doubles as an accept cycle for the next operation.
        if (out_ready) begin
          in_ready   = 1'b1;
          state_next = in_valid ? RUN : IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_reg   <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      sum_reg   <= '0;
      carry_reg <= 1'b0;
      cout_reg  <= 1'b0;
    end else if (accept) begin
      idx_reg   <= '0;
      a_reg     <= a;
      b_reg     <= b;
      carry_reg <= cin;
    end else if (state_reg == RUN) begin
      idx_reg   <= idx_reg + IW'(1);
      carry_reg <= slice_cout;
      for (int k = 0; k < K; k++) begin
        if (idx_reg == IW'(k)) sum_reg[k*N +: N] <= slice_sum;
      end
      if (last_slice) cout_reg <= slice_cout;
    end
  end

  assign sum  = sum_reg;
  assign cout = cout_reg;

endmodule

// File: tb/tb_multiword_adder.sv
// Self-checking bench for multiword_adder: table vectors, random operands
// against an arithmetic model, backpressure, back-to-back and reset cases.
module tb_multiword_adder;

  logic        clk;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready, cin, cout, busy;
  logic [31:0] a, b, sum;

  logic        in_valid_k1, in_ready_k1, out_valid_k1, out_ready_k1, cin_k1, cout_k1, busy_k1;
  logic [31:0] a_k1, b_k1, sum_k1;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic [31:0] exp_sum;
    logic        exp_cout;
  } vec_t;

  vec_t vecs [6];

  multiword_adder #(.W(32), .N(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .busy(busy)
  );

  multiword_adder #(.W(32), .N(32)) dut_k1 (
    .clk(clk), .rst(rst), .in_valid(in_valid_k1), .in_ready(in_ready_k1),
    .a(a_k1), .b(b_k1), .cin(cin_k1), .out_valid(out_valid_k1), .out_ready(out_ready_k1),
    .sum(sum_k1), .cout(cout_k1), .busy(busy_k1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  function automatic logic [32:0] ref_add(input logic [31:0] x, input logic [31:0] y, input logic c);
    return {1'b0, x} + {1'b0, y} + 33'(c);
  endfunction

  // Accept one operand set, wait for the result, hand it off.
  task automatic run_op(input logic [31:0] oa, input logic [31:0] ob, input logic oc,
                        output logic [31:0] rs, output logic rc, output int lat);
    chk("pre_accept_in_ready", 64'(in_ready), 64'd1);
    a = oa; b = ob; cin = oc; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = 32'hDEAD_BEEF; b = 32'hFEED_F00D; cin = 1'b1;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    rs = sum; rc = cout;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    logic [31:0] rs, ea, eb;
    logic        rc, ec, acc, hand;
    logic [32:0] exp_r;
    logic [32:0] q [$];
    int          lat, cyc, results, last_hand, n;

    vecs[0] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1};
    vecs[1] = '{32'h1234_5678, 32'h1111_1111, 1'b1, 32'h2345_678A, 1'b0};
    vecs[2] = '{32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0000_0001, 1'b0};
    vecs[3] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1};
    vecs[4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1};
    vecs[5] = '{32'h00FF_00FF, 32'h0001_0001, 1'b0, 32'h0100_0100, 1'b0};

    rst = 1'b1;
    in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0;
    in_valid_k1 = 1'b0; out_ready_k1 = 1'b0; a_k1 = '0; b_k1 = '0; cin_k1 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_sum", 64'(sum), 64'd0);
    chk("reset_cout", 64'(cout), 64'd0);
    rst = 1'b0;

    // Table vectors; first accept lands on the first edge after reset release.
    for (int i = 0; i < 6; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].cin, rs, rc, lat);
      chk($sformatf("vec%0d_sum", i), 64'(rs), 64'(vecs[i].exp_sum));
      chk($sformatf("vec%0d_cout", i), 64'(rc), 64'(vecs[i].exp_cout));
      chk($sformatf("vec%0d_latency", i), 64'(lat), 64'd4);
    end

    // Random operands against the arithmetic model.
    for (int i = 0; i < 16; i++) begin
      ea = $urandom; eb = $urandom; ec = 1'($urandom_range(0, 1));
      exp_r = ref_add(ea, eb, ec);
      run_op(ea, eb, ec, rs, rc, lat);
      chk($sformatf("rand%0d_result", i), 64'({rc, rs}), 64'(exp_r));
      chk($sformatf("rand%0d_latency", i), 64'(lat), 64'd4);
    end

    // Backpressure: result must hold, new operands must be refused.
    ea = 32'hA5A5_A5A5; eb = 32'h5A5A_5A5A; ec = 1'b1;
    a = ea; b = eb; cin = ec; in_valid = 1'b1;
    @(posedge clk); #1;
    a = 32'h1111_1111; b = 32'h2222_2222; cin = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("bp_latency", 64'(n), 64'd4);
    exp_r = ref_add(ea, eb, ec);
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("bp%0d_hold", i), 64'({out_valid, in_ready, cout, sum}),
          64'({1'b1, 1'b0, exp_r[32], exp_r[31:0]}));
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp_after_handoff_idle", 64'({out_valid, busy, in_ready}), 64'b001);

    // Back-to-back with in_valid and out_ready held high.
    in_valid = 1'b1; out_ready = 1'b1;
    a = $urandom; b = $urandom; cin = 1'($urandom_range(0, 1));
    cyc = 0; results = 0; last_hand = -1;
    while (results < 12 && cyc < 300) begin
      acc  = in_valid && in_ready;
      hand = out_valid && out_ready;
      if (hand) begin
        chk($sformatf("b2b%0d_in_ready", results), 64'(in_ready), 64'd1);
        if (q.size() == 0) begin
          chk("b2b_unexpected_result", 64'd0, 64'd1);
        end else begin
          exp_r = q.pop_front();
          chk($sformatf("b2b%0d_result", results), 64'({cout, sum}), 64'(exp_r));
        end
        if (last_hand >= 0) chk($sformatf("b2b%0d_period", results), 64'(cyc - last_hand), 64'd5);
        last_hand = cyc;
        results++;
      end
      if (acc) q.push_back(ref_add(a, b, cin));
      @(posedge clk); #1;
      cyc++;
      if (acc) begin
        a = $urandom; b = $urandom; cin = 1'($urandom_range(0, 1));
      end
    end
    chk("b2b_result_count", 64'(results), 64'd12);
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("b2b_drain_valid", 64'(out_valid), 64'd1);
    if (q.size() == 0) begin
      chk("b2b_drain_queue", 64'd0, 64'd1);
    end else begin
      exp_r = q.pop_front();
      chk("b2b_drain_result", 64'({cout, sum}), 64'(exp_r));
    end
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("b2b_end_idle", 64'({out_valid, busy, in_ready}), 64'b001);

    // Reset while RUN is at slice index 2.
    a = 32'h7777_7777; b = 32'h9999_9999; cin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    chk("midrun_busy_before_rst", 64'(busy), 64'd1);
    rst = 1'b1;
    #1;
    chk("midrun_rst_state", 64'({out_valid, busy, in_ready}), 64'b001);
    @(posedge clk); #1;
    rst = 1'b0;
    n = 0;
    for (int i = 0; i < 6; i++) begin
      if (out_valid) n++;
      @(posedge clk); #1;
    end
    chk("midrun_no_out_valid", 64'(n), 64'd0);
    chk("midrun_idle_in_ready", 64'(in_ready), 64'd1);
    run_op(32'h0F0F_0F0F, 32'hF0F0_F0F1, 1'b0, rs, rc, lat);
    chk("after_rst_result", 64'({rc, rs}), 64'(ref_add(32'h0F0F_0F0F, 32'hF0F0_F0F1, 1'b0)));
    chk("after_rst_latency", 64'(lat), 64'd4);

    // Single-slice configuration: exactly one RUN cycle.
    chk("k1_idle_in_ready", 64'(in_ready_k1), 64'd1);
    a_k1 = 32'h0; b_k1 = 32'h0; cin_k1 = 1'b1; in_valid_k1 = 1'b1;
    @(posedge clk); #1;
    in_valid_k1 = 1'b0;
    chk("k1_run_state", 64'({out_valid_k1, busy_k1, in_ready_k1}), 64'b010);
    @(posedge clk); #1;
    chk("k1_out_valid", 64'(out_valid_k1), 64'd1);
    chk("k1_result", 64'({cout_k1, sum_k1}), 64'h0_0000_0001);
    out_ready_k1 = 1'b1;
    @(posedge clk); #1;
    out_ready_k1 = 1'b0;
    chk("k1_back_idle", 64'({out_valid_k1, busy_k1, in_ready_k1}), 64'b001);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/multiword_adder.md
MULTIWORD_ADDER -- requirements
Module: multiword_adder

Interface
REQ-001 Parameter W, default 32: full operand width in bits.
REQ-002 Parameter N, default 8: slice width in bits, i.e. the width of the adder instance used per cycle.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  operand set offered.
REQ-006 in_ready  output  1  block can accept an operand set this cycle.
REQ-007 a  input  W  operand A.
REQ-008 b  input  W  operand B.
REQ-009 cin  input  1  carry-in.
REQ-010 out_valid  output  1  result available.
REQ-011 out_ready  input  1  consumer accepts the result.
REQ-012 sum  output  W  (a + b + cin) mod 2^W.
REQ-013 cout  output  1  carry out of bit W-1.
REQ-014 busy  output  1  high in RUN state.

Function
REQ-015 W SHALL be an integer multiple of N; K = W/N slices, K >= 1; violation SHALL be an elaboration error.
REQ-016 FSM states SHALL be IDLE, RUN and DONE.
REQ-017 IDLE: in_ready=1; on in_valid, latch a, b and cin, clear the slice index, then go to RUN.
REQ-018 RUN: each cycle add slice[idx] of A and B plus the registered carry, write the N-bit result into sum slice[idx], register the slice carry-out, and increment idx.
REQ-019 RUN: after processing slice K-1, store the final carry into cout and go to DONE.
REQ-020 Latency: out_valid SHALL rise exactly K cycles after the accepting edge; the K=1 case SHALL also take exactly one RUN cycle.
REQ-021 DONE: out_valid=1; sum and cout SHALL hold stable until handoff (out_valid and out_ready both high).
REQ-022 DONE with out_ready=0: in_ready=0, and in_valid SHALL be ignored.
REQ-023 DONE with out_ready=1 and in_valid=0: go to IDLE.
REQ-024 DONE with out_ready=1 and in_valid=1 in the same cycle: hand off the result and accept the new operands; go directly to RUN; in_ready=1 in that cycle.
REQ-025 Throughput: one result per K+1 cycles under continuous valid/ready.
REQ-026 in_ready SHALL be 0 throughout RUN; a, b and cin SHALL be sampled only at the accepting edge.
REQ-027 sum SHALL be a register; its contents outside DONE are don't-care for the consumer.
REQ-028 Carry propagation between slices SHALL be through the registered carry only; there is no combinational path from a to sum.

Reset
REQ-029 rst SHALL force state=IDLE, idx=0, the carry register=0, sum=0, cout=0, out_valid=0 and busy=0; in_ready SHALL be 1 while in IDLE.
REQ-030 Reset asserted mid-RUN or in DONE SHALL discard the operation with no output handoff.
REQ-031 The first accept SHALL be possible on the first rising edge after rst deasserts.

Structure
REQ-032 The state enum (IDLE/RUN/DONE) SHALL reside in the shared arithmetic package, named adder_pkg.
REQ-033 The slice adder SHALL be one instance of the existing carry_lookahead_adder with parameter N; no other sub-modules.
REQ-034 The slice index counter SHALL be $clog2(K)+1 bits wide so the terminal compare never wraps.

Verification (W=32, N=8, K=4)
REQ-035 a=0xFFFFFFFF, b=0x00000001, cin=0 -> sum=0x00000000, cout=1, out_valid exactly 4 cycles after accept.
REQ-036 a=0x12345678, b=0x11111111, cin=1 -> sum=0x2345678A, cout=0.
REQ-037 a=0, b=0, cin=1 -> sum=0x00000001, cout=0; with N=32 (K=1), out_valid 1 cycle after accept.
REQ-038 Backpressure: out_ready held 0 for 10 cycles in DONE while in_valid=1 -> sum/cout stable, in_ready=0, no accept.
REQ-039 Back-to-back: in_valid and out_ready tied high with random operands -> a new accept on each handoff cycle, one result per 5 cycles, all sums match a reference model.
REQ-040 rst pulsed at RUN idx=2 -> out_valid never asserts for that operation; in IDLE after reset with in_ready=1; the next operation is correct.
